// File: rtl/instruction_encoder_if.sv
// Field-bundle input and encoded-word output bus of the instruction encoder.
// slave is the encoder's view; master is the producer/consumer side.
interface instruction_encoder_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       fmt;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [2:0]       funct3;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [6:0]       funct7;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic             err_sticky;
  logic             err_clr;
  logic [CNT_W-1:0] enc_count;

  modport slave (
    input  in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready, err_clr,
    output in_ready, out_valid, out_instr, out_err, err_sticky, enc_count
  );

  modport master (
    output in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready, err_clr,
    input  in_ready, out_valid, out_instr, out_err, err_sticky, enc_count
  );
endinterface

// File: rtl/instruction_encoder.sv
// Packs RV32I fields into a 32-bit instruction word, flags illegal immediates,
// and buffers {err,word} in a DEPTH-entry FIFO drained by valid/ready.
module instruction_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  reset_n,
  instruction_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
                         FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5;

  logic [32:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_occ;
  logic [32:0]      r_last;
  logic             r_sticky;
  logic [CNT_W-1:0] r_enc;

  logic [31:0] w_word;
  logic        w_err, w_full, w_empty, w_push, w_pop;
  logic        w_sx11, w_sx12, w_sx20;
  logic [32:0] w_head;

  // Immediate fits the format when all bits above the field's sign bit match it.
  assign w_sx11 = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
  assign w_sx12 = (&bus.imm[31:12]) | ~(|bus.imm[31:12]);
  assign w_sx20 = (&bus.imm[31:20]) | ~(|bus.imm[31:20]);

  always_comb begin
    w_word = '0;
    w_err  = 1'b0;
    case (bus.fmt)
      FMT_R: w_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      FMT_I: begin
        w_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        w_err  = ~w_sx11;
      end
      FMT_S: begin
        w_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
        w_err  = ~w_sx11;
      end
      FMT_B: begin
        w_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                  bus.imm[4:1], bus.imm[11], bus.opcode};
        w_err  = ~w_sx12 | bus.imm[0];
      end
      FMT_U: begin
        w_word = {bus.imm[31:12], bus.rd, bus.opcode};
        w_err  = |bus.imm[11:0];
      end
      FMT_J: begin
        w_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.opcode};
        w_err  = ~w_sx20 | bus.imm[0];
      end
      default: w_err = 1'b1;
    endcase
  end

  assign w_full  = (r_occ == (AW+1)'(DEPTH));
  assign w_empty = (r_occ == '0);
  assign w_push  = bus.in_valid & ~w_full;
  assign w_pop   = ~w_empty & bus.out_ready;

  // When drained, the output shows the last popped word rather than a stale slot.
  assign w_head = w_empty ? r_last : r_mem[r_rptr];

  assign bus.in_ready   = ~w_full;
  assign bus.out_valid  = ~w_empty;
  assign bus.out_instr  = w_head[31:0];
  assign bus.out_err    = w_head[32];
  assign bus.err_sticky = r_sticky;
  assign bus.enc_count  = r_enc;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {w_err, w_word};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_occ    <= '0;
      r_last   <= '0;
      r_sticky <= 1'b0;
      r_enc    <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_last <= r_mem[r_rptr];
        r_enc  <= r_enc + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      if (w_push && w_err) r_sticky <= 1'b1;
      else if (bus.err_clr) r_sticky <= 1'b0;
    end
  end
endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: expected {err,word} queued at push, compared at pop.
module tb_instruction_encoder;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int TMO   = 50;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
  } bundle_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instruction_encoder_if #(.CNT_W(CNT_W)) bus();
  instruction_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [32:0] sb[$];

  function automatic bundle_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [6:0] f7, input logic [31:0] imm);
    bundle_t b;
    b.fmt = fmt; b.op = op; b.rd = rd; b.f3 = f3; b.rs1 = rs1; b.rs2 = rs2; b.f7 = f7; b.imm = imm;
    return b;
  endfunction

  // Reference encoder: bit-slice placement and signed range checks.
  function automatic logic [32:0] model(input bundle_t b);
    logic [31:0] w;
    logic [31:0] i;
    logic e;
    w = '0; e = 1'b0; i = b.imm;
    if (b.fmt <= 3'd5) w[6:0] = b.op;
    case (b.fmt)
      3'd0: begin
        w[31:25] = b.f7; w[24:20] = b.rs2; w[19:15] = b.rs1; w[14:12] = b.f3; w[11:7] = b.rd;
      end
      3'd1: begin
        w[31:20] = i[11:0]; w[19:15] = b.rs1; w[14:12] = b.f3; w[11:7] = b.rd;
        e = ($signed(i) < -2048) || ($signed(i) > 2047);
      end
      3'd2: begin
        w[31:25] = i[11:5]; w[24:20] = b.rs2; w[19:15] = b.rs1; w[14:12] = b.f3; w[11:7] = i[4:0];
        e = ($signed(i) < -2048) || ($signed(i) > 2047);
      end
      3'd3: begin
        w[31] = i[12]; w[30:25] = i[10:5]; w[24:20] = b.rs2; w[19:15] = b.rs1; w[14:12] = b.f3;
        w[11:8] = i[4:1]; w[7] = i[11];
        e = ($signed(i) < -4096) || ($signed(i) > 4095) || i[0];
      end
      3'd4: begin
        w[31:12] = i[31:12]; w[11:7] = b.rd;
        e = (i[11:0] != 12'h0);
      end
      3'd5: begin
        w[31] = i[20]; w[30:21] = i[10:1]; w[20] = i[11]; w[19:12] = i[19:12]; w[11:7] = b.rd;
        e = ($signed(i) < -1048576) || ($signed(i) > 1048575) || i[0];
      end
      default: e = 1'b1;
    endcase
    return {e, w};
  endfunction

  task automatic drive(input bundle_t b);
    bus.fmt = b.fmt; bus.opcode = b.op; bus.rd = b.rd; bus.funct3 = b.f3;
    bus.rs1 = b.rs1; bus.rs2 = b.rs2; bus.funct7 = b.f7; bus.imm = b.imm;
  endtask

  task automatic push(input bundle_t b, input logic [32:0] exp);
    int n = 0;
    @(negedge clk);
    drive(b);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) begin
      errors++;
      $display("FAIL push_timeout in_ready=%b required 1", bus.in_ready);
    end else begin
      sb.push_back(exp);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic pop(output logic [32:0] got);
    int n = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    while (!bus.out_valid && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) begin
      errors++;
      $display("FAIL pop_timeout out_valid=%b required 1", bus.out_valid);
      got = 'x;
    end else begin
      got = {bus.out_err, bus.out_instr};
      exp_cnt++;
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_err, bus.err_sticky} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b required 000", {bus.out_valid, bus.out_err, bus.err_sticky});
    end
    checks++;
    if (bus.out_instr !== 32'h0) begin
      errors++; $display("FAIL reset_instr got %h required 0", bus.out_instr);
    end
    checks++;
    if (bus.enc_count !== '0) begin
      errors++; $display("FAIL reset_count got %0d required 0", bus.enc_count);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b required 1", bus.in_ready);
    end
    exp_cnt = 0;
  endtask

  task automatic test_formats();
    logic [32:0] got, exp;
    push(mk(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0), {1'b0, 32'h002081B3});
    checks++;
    if ({bus.out_valid, bus.out_instr} !== {1'b1, 32'h002081B3}) begin
      errors++; $display("FAIL latency got v=%b %h required v=1 002081b3", bus.out_valid, bus.out_instr);
    end
    push(mk(3'd1, 7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF), {1'b0, 32'hFFF00293});
    push(mk(3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8), {1'b0, 32'h0020A423});
    push(mk(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC), {1'b0, 32'hFE208EE3});
    for (int k = 0; k < 4; k++) begin
      pop(got);
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL format_%0d got %h required %h", k, got, exp);
      end
      if (k == 0) begin
        checks++;
        if (bus.enc_count !== 4'(exp_cnt)) begin
          errors++; $display("FAIL count_first got %0d required %0d", bus.enc_count, exp_cnt);
        end
      end
    end
    push(mk(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048), {1'b0, 32'h001000EF});
    push(mk(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000), {1'b0, 32'h123452B7});
    for (int k = 0; k < 2; k++) begin
      pop(got);
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL format_ju_%0d got %h required %h", k, got, exp);
      end
    end
    checks++;
    if ({bus.out_valid, bus.out_instr} !== {1'b0, 32'h123452B7}) begin
      errors++; $display("FAIL empty_hold got v=%b %h required v=0 123452b7", bus.out_valid, bus.out_instr);
    end
  endtask

  task automatic test_errors();
    logic [32:0] got, exp;
    bundle_t b;
    b = mk(3'd1, 7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
    push(b, model(b));
    checks++;
    if (bus.err_sticky !== 1'b1) begin
      errors++; $display("FAIL sticky_set got %b required 1", bus.err_sticky);
    end
    pop(got);
    exp = sb.pop_front();
    checks++;
    if (got !== {1'b1, 32'h80000293} || got !== exp) begin
      errors++; $display("FAIL i_imm_err got %h required %h", got, exp);
    end
    @(negedge clk); bus.err_clr = 1'b1;
    @(posedge clk); #1 bus.err_clr = 1'b0;
    checks++;
    if (bus.err_sticky !== 1'b0) begin
      errors++; $display("FAIL sticky_clr got %b required 0", bus.err_sticky);
    end
    b = mk(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd3);
    push(b, model(b));
    b = mk(3'd7, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    push(b, {1'b1, 32'h0});
    b = mk(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_1001);
    push(b, model(b));
    for (int k = 0; k < 3; k++) begin
      pop(got);
      exp = sb.pop_front();
      checks++;
      if (got !== exp || got[32] !== 1'b1) begin
        errors++; $display("FAIL err_case_%0d got %h required %h", k, got, exp);
      end
    end
    bus.err_clr = 1'b1;
    b = mk(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
    push(b, model(b));
    bus.err_clr = 1'b0;
    checks++;
    if (bus.err_sticky !== 1'b1) begin
      errors++; $display("FAIL sticky_set_wins got %b required 1", bus.err_sticky);
    end
    pop(got);
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL j_odd got %h required %h", got, exp);
    end
    @(negedge clk); bus.err_clr = 1'b1;
    @(posedge clk); #1 bus.err_clr = 1'b0;
  endtask

  task automatic test_full_back_to_back();
    logic [32:0] exp;
    bundle_t b;
    for (int k = 0; k < DEPTH; k++) begin
      b = mk(3'd0, 7'h33, 5'(k + 1), 3'd0, 5'd1, 5'd2, 7'(k), 32'd0);
      push(b, model(b));
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_instr !== sb[0][31:0]) begin
      errors++; $display("FAIL full_head got rdy=%b %h required rdy=0 %h", bus.in_ready, bus.out_instr, sb[0][31:0]);
    end
    b = mk(3'd0, 7'h33, 5'd9, 3'd0, 5'd1, 5'd2, 7'd9, 32'd0);
    drive(b);
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_instr !== sb[0][31:0]) begin
      errors++; $display("FAIL full_hold got rdy=%b %h required rdy=0 %h", bus.in_ready, bus.out_instr, sb[0][31:0]);
    end
    bus.out_ready = 1'b1;
    exp = sb.pop_front();
    checks++;
    if ({bus.out_err, bus.out_instr} !== exp) begin
      errors++; $display("FAIL full_pop got %h required %h", {bus.out_err, bus.out_instr}, exp);
    end
    exp_cnt++;
    @(posedge clk); #1 bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_pop got %b required 1", bus.in_ready);
    end
    @(posedge clk); #1 bus.in_valid = 1'b0;
    sb.push_back(model(b));
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      exp = sb.pop_front();
      checks++;
      if ({bus.out_err, bus.out_instr} !== exp) begin
        errors++; $display("FAIL drain_%0d got %h required %h", k, {bus.out_err, bus.out_instr}, exp);
      end
      exp_cnt++;
      @(posedge clk); #1 bus.out_ready = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      b = mk(3'd1, 7'h13, 5'(k), 3'd0, 5'd0, 5'd0, 7'd0, 32'(k * 4));
      push(b, model(b));
    end
    // Simultaneous push and pop at occupancy 3: in_ready must stay high throughout.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_occ_%0d got rdy=%b v=%b required 1 1", k, bus.in_ready, bus.out_valid);
      end
      exp = sb.pop_front();
      checks++;
      if ({bus.out_err, bus.out_instr} !== exp) begin
        errors++; $display("FAIL b2b_data_%0d got %h required %h", k, {bus.out_err, bus.out_instr}, exp);
      end
      b = mk(3'd2, 7'h23, 5'd0, 3'd2, 5'(k), 5'(k + 7), 7'd0, 32'(k * 8));
      drive(b);
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back(model(b));
      exp_cnt++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_not_full got %b required 1", bus.in_ready);
    end
    b = mk(3'd0, 7'h33, 5'd1, 3'd0, 5'd1, 5'd1, 7'd0, 32'd0);
    push(b, model(b));
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_full got %b required 0", bus.in_ready);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.enc_count !== '0) begin
      errors++; $display("FAIL async_reset got v=%b cnt=%0d required v=0 cnt=0", bus.out_valid, bus.enc_count);
    end
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_wrap();
    logic [32:0] got, exp;
    logic [31:0] r;
    bundle_t b;
    for (int k = 0; k < (1 << CNT_W); k++) begin
      r = $urandom;
      b = mk(3'($urandom_range(0, 5)), 7'($urandom), 5'($urandom), 3'($urandom),
             5'($urandom), 5'($urandom), 7'($urandom), r[0] ? r : {{19{r[13]}}, r[13:2], 1'b0});
      push(b, model(b));
      pop(got);
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL wrap_data_%0d got %h required %h", k, got, exp);
      end
      checks++;
      if (bus.enc_count !== 4'(exp_cnt)) begin
        errors++; $display("FAIL wrap_count_%0d got %0d required %0d", k, bus.enc_count, exp_cnt % 16);
      end
    end
    checks++;
    if (bus.enc_count !== 4'd0) begin
      errors++; $display("FAIL count_wrap got %0d required 0", bus.enc_count);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.err_clr = 1'b0;
    drive(mk(3'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0));
    test_reset();
    test_formats();
    test_errors();
    test_full_back_to_back();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
